concat: RTL and testbench
=========================

// Module: concat
// PURPOSE
//  Registered feature/context concatenation stage for the hyperprior/entropy datapath.
//  Joins a FEATURE_WIDTH feature vector and a CONTEXT_WIDTH context vector into one word.
//  feature occupies the MSBs of the output; context2 occupies the LSBs.
//  Uses ready/valid handshakes with a 2-entry skid buffer: full throughput, ordering preserved, back-pressure tolerant.
// PARAMETERS
//  FEATURE_WIDTH  128  width of feature input (>=1)
//  CONTEXT_WIDTH  384  width of context2 input (>=1)
//  TOTAL_WIDTH    FEATURE_WIDTH+CONTEXT_WIDTH  derived, localparam, not overridable
// PORTS
//  clk         in   1              single clock, all state on rising edge
//  rst         in   1              reset, synchronous, active-high
//  in_valid    in   1              feature/context2 valid this cycle
//  in_ready    out  1              stage can accept input this cycle
//  feature     in   FEATURE_WIDTH  feature vector
//  context2    in   CONTEXT_WIDTH  context vector
//  out_valid   out  1              concat_out holds a valid word
//  out_ready   in   1              downstream accepts word this cycle
//  concat_out  out  TOTAL_WIDTH    {feature, context2}
// BEHAVIOUR
//  - Handshake definitions:
//    - in_fire  = in_valid & in_ready
//    - out_fire = out_valid & out_ready
//  - Concatenation: word = {feature, context2}
//    - concat_out[TOTAL-1 -: FEATURE_WIDTH] = feature
//    - concat_out[CONTEXT_WIDTH-1:0] = context2
//    - No bit reversal, padding or arithmetic.
//  - Reset (sampled at posedge with rst=1):
//    - out_valid=0, skid_valid=0, concat_out=0, skid data=0.
//    - in_ready=1 from the first cycle after reset.
//    - Reset mid-transfer discards both stored words; no output pulse.
//  - State: output register (out_valid, concat_out) plus skid register (skid_valid, skid_data).
//  - in_ready is registered: in_ready = !skid_valid.
//  - Output register update, when !out_valid | out_ready:
//    - skid_valid: load skid_data, set skid_valid=0.
//    - else if in_fire: load input word, out_valid=1.
//    - else: out_valid=0; concat_out holds its last value.
//  - Skid capture: in_fire while out_valid & !out_ready -> skid_data=word, skid_valid=1, so in_ready=0 next cycle.
//  - Latency: 1 cycle, from in_fire to out_valid on an unstalled path.
//  - Throughput: 1 word/cycle while out_ready=1.
//  - Stalled output: concat_out and out_valid stay stable while out_valid & !out_ready.
//  - Simultaneous out_fire and skid_valid: skid word moves to output; in_ready returns to 1 next cycle.
//  - in_valid while in_ready=0 is ignored; inputs are not sampled.
//  - No combinational path from any input to any output.
// TESTING
//  1. Reset: assert rst 2 cycles with random inputs -> out_valid=0, concat_out=0, in_ready=1 after release.
//  2. Single word, out_ready=1:
//     - stimulus: feature=128'h0123456789ABCDEF0123456789ABCDEF,
//       context2=384'hFEDCBA9876543210 repeated 4x (upper 128 bits zero)
//     - response: next cycle out_valid=1, concat_out={feature,context2};
//       bits[511:384]=feature, bits[383:256]=0.
//  3. Extremes, back-to-back at 1/cycle:
//     - feature=all-1s, context2=0 -> concat_out[511:384]=all-1s, rest 0.
//     - then feature=0, context2=all-1s (384 bits) -> concat_out[511:384]=0, [383:0]=all-1s.
//  4. Back-pressure: out_ready=0, push 2 words -> in_ready drops after the 2nd; 3rd push ignored.
//     Raise out_ready -> words emerge in order, no loss, no duplication.
//  5. Random in_valid/out_ready, 10k words -> scoreboard matches {feature,context2} in order.
//  6. rst asserted while skid full -> both words dropped, out_valid=0 next cycle.

Source files
------------

// File: rtl/concat.sv
// concat: registered {feature, context2} join with a 2-entry ready/valid skid buffer
module concat #(
  parameter int FEATURE_WIDTH = 128,
  parameter int CONTEXT_WIDTH = 384
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [FEATURE_WIDTH-1:0]               feature,
  input  logic [CONTEXT_WIDTH-1:0]               context2,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [FEATURE_WIDTH+CONTEXT_WIDTH-1:0] concat_out
);
  localparam int TOTAL_WIDTH = FEATURE_WIDTH + CONTEXT_WIDTH;
  logic                   skid_valid;
  logic [TOTAL_WIDTH-1:0] skid_data;
  logic [TOTAL_WIDTH-1:0] word;
  logic                   in_fire;
  logic                   out_free;
  // in_ready comes straight from the skid flop, so no input reaches an output combinationally
  always_comb begin
    word     = {feature, context2};
    in_ready = !skid_valid;
    in_fire  = in_valid && in_ready;
    out_free = !out_valid || out_ready;
  end
  // output stage drains the skid word first; a stalled accept parks in the skid register
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      concat_out <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (out_free) begin
      out_valid  <= skid_valid || in_fire;
      concat_out <= skid_valid ? skid_data : in_fire ? word : concat_out;
      skid_valid <= 1'b0;
    end else if (in_fire) begin
      skid_data  <= word;
      skid_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_concat.sv
// tb_concat: directed and scoreboarded checks of the concat skid stage
module tb_concat;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] feature = '0;
  logic [383:0] context2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [511:0] concat_out;
  int           vectors = 0;
  int           miscompares = 0;
  logic [511:0] sb[$];
  logic [511:0] exp_w;
  logic [127:0] fa, fb, fc;
  logic [383:0] ca, cb, cc;
  int           sent, rcvd, cycles;

  concat dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .feature(feature), .context2(context2), .out_valid(out_valid),
    .out_ready(out_ready), .concat_out(concat_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd_f();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [383:0] rnd_c();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 1'b1;
    feature = rnd_f();
    context2 = rnd_c();
    tick();
    feature = rnd_f();
    context2 = rnd_c();
    tick();
    check("rst_out_valid", 512'(out_valid), 512'(0));
    check("rst_concat_out", concat_out, '0);
    check("rst_in_ready", 512'(in_ready), 512'(1));
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("idle_out_valid", 512'(out_valid), 512'(0));

    fa = 128'h0123456789ABCDEF0123456789ABCDEF;
    ca = {128'h0, {4{64'hFEDCBA9876543210}}};
    feature = fa;
    context2 = ca;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_valid", 512'(out_valid), 512'(1));
    check("single_word", concat_out, {fa, ca});
    check("single_msb", 512'(concat_out[511:384]), 512'(fa));
    check("single_zero_band", 512'(concat_out[383:256]), 512'(0));
    tick();
    check("single_drop_valid", 512'(out_valid), 512'(0));
    check("single_hold_data", concat_out, {fa, ca});

    feature = '1;
    context2 = '0;
    in_valid = 1'b1;
    tick();
    check("ext1_valid", 512'(out_valid), 512'(1));
    check("ext1_word", concat_out, {128'h0, 384'h0} | {{128{1'b1}}, 384'h0});
    feature = '0;
    context2 = '1;
    tick();
    in_valid = 1'b0;
    check("ext2_valid", 512'(out_valid), 512'(1));
    check("ext2_msb", 512'(concat_out[511:384]), 512'(0));
    check("ext2_lsb", 512'(concat_out[383:0]), {128'h0, {384{1'b1}}});
    tick();
    check("ext_idle", 512'(out_valid), 512'(0));

    fa = 128'hA1; ca = 384'hA2;
    fb = 128'hB1; cb = 384'hB2;
    fc = 128'hC1; cc = 384'hC2;
    out_ready = 1'b0;
    feature = fa; context2 = ca; in_valid = 1'b1;
    tick();
    check("bp_a_valid", 512'(out_valid), 512'(1));
    check("bp_a_word", concat_out, {fa, ca});
    check("bp_ready_after_1", 512'(in_ready), 512'(1));
    feature = fb; context2 = cb;
    tick();
    check("bp_ready_after_2", 512'(in_ready), 512'(0));
    check("bp_stall_word", concat_out, {fa, ca});
    feature = fc; context2 = cc;
    tick();
    check("bp_still_full", 512'(in_ready), 512'(0));
    check("bp_stall_valid", 512'(out_valid), 512'(1));
    check("bp_stall_word2", concat_out, {fa, ca});
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_b_valid", 512'(out_valid), 512'(1));
    check("bp_b_word", concat_out, {fb, cb});
    check("bp_ready_back", 512'(in_ready), 512'(1));
    tick();
    check("bp_no_dup_c", 512'(out_valid), 512'(0));

    out_ready = 1'b0;
    feature = fa; context2 = ca; in_valid = 1'b1;
    tick();
    feature = fb; context2 = cb;
    tick();
    check("rstmid_full", 512'(in_ready), 512'(0));
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    check("rstmid_out_valid", 512'(out_valid), 512'(0));
    check("rstmid_in_ready", 512'(in_ready), 512'(1));
    check("rstmid_data", concat_out, '0);
    tick();
    check("rstmid_no_pulse", 512'(out_valid), 512'(0));

    sent = 0;
    rcvd = 0;
    cycles = 0;
    while (rcvd < 10000 && cycles < 60000) begin
      in_valid = (sent < 10000) && ($urandom_range(3) != 0);
      out_ready = $urandom_range(3) != 0;
      feature = rnd_f();
      context2 = rnd_c();
      if (in_valid && in_ready) begin
        sb.push_back({feature, context2});
        sent++;
      end
      if (out_valid && out_ready) begin
        exp_w = sb.size() > 0 ? sb.pop_front() : 'x;
        check("rand_word", concat_out, exp_w);
        rcvd++;
      end
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    check("rand_received", 512'(rcvd), 512'(10000));
    check("rand_sb_empty", 512'(sb.size()), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
